// File: rtl/bf16_unit_arbiter.sv
// Purpose : round-robin share of one pipelined bf16 fmadd/fmsub datapath among NREQ requesters.
// Latency : grant at edge t drives unit_* in t+1; owner sees resp_valid in t+LATENCY+1.
// Backpres: per-requester valid/ready; arb_hold stalls new grants only. Responses cannot be stalled.
//
// Ports:
//   clk, reset (synchronous, active-low), arb_hold
//   req_valid/req_ready, req_in1/2/3, req_funct5 : per-requester slices (16/16/16/5 bits each)
//   unit_in1/2/3, unit_funct5, unit_issue       : registered issue into the datapath
//   unit_result                                  : datapath result, LATENCY cycles after unit_*
//   resp_valid (one-hot owner), resp_result      : result routed back to the requester
//   stat_count                                   : per-requester issue counters
// Build option: define BF16_ARB_STATS_EN to enable saturating stat_count counters;
// otherwise stat_count is tied to zero. LATENCY must be at least 1.
module bf16_unit_arbiter #(
  parameter int NREQ    = 2,
  parameter int LATENCY = 3,
  parameter int IDXW    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arb_hold,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [16*NREQ-1:0]   req_in1,
  input  logic [16*NREQ-1:0]   req_in2,
  input  logic [16*NREQ-1:0]   req_in3,
  input  logic [5*NREQ-1:0]    req_funct5,
  output logic [15:0]          unit_in1,
  output logic [15:0]          unit_in2,
  output logic [15:0]          unit_in3,
  output logic [4:0]           unit_funct5,
  output logic                 unit_issue,
  input  logic [15:0]          unit_result,
  output logic [NREQ-1:0]      resp_valid,
  output logic [15:0]          resp_result,
  output logic [16*NREQ-1:0]   stat_count
);

  logic [IDXW-1:0] rr_ptr;
  // Low from reset until one edge after release, so no grant is offered on the
  // first cycle out of reset.
  logic            ready_en;
  logic            grant_found;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] cand_idx;
  logic            handshake;

  // Round-robin search starting just after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_idx = IDXW'((int'(rr_ptr) + k) % NREQ);
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // A winner always has req_valid set, so an offered grant is a handshake.
  assign handshake = grant_found & ~arb_hold & ready_en & reset;
  assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      unit_in1    <= '0;
      unit_in2    <= '0;
      unit_in3    <= '0;
      unit_funct5 <= '0;
      unit_issue  <= 1'b0;
      rr_ptr      <= IDXW'(NREQ - 1);
      ready_en    <= 1'b0;
    end else begin
      ready_en   <= 1'b1;
      unit_issue <= handshake;
      if (handshake) begin
        unit_in1    <= req_in1[int'(grant_idx)*16 +: 16];
        unit_in2    <= req_in2[int'(grant_idx)*16 +: 16];
        unit_in3    <= req_in3[int'(grant_idx)*16 +: 16];
        unit_funct5 <= req_funct5[int'(grant_idx)*5 +: 5];
        rr_ptr      <= grant_idx;
      end
    end
  end

  // Ownership tags: stage 0 lines up with unit_*, stage LATENCY with unit_result.
  logic [LATENCY:0] tag_vld;
  logic [IDXW-1:0]  tag_idx [0:LATENCY];

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_vld <= '0;
      for (int i = 0; i <= LATENCY; i++) begin
        tag_idx[i] <= '0;
      end
    end else begin
      tag_vld    <= {tag_vld[LATENCY-1:0], handshake};
      tag_idx[0] <= grant_idx;
      for (int i = 1; i <= LATENCY; i++) begin
        tag_idx[i] <= tag_idx[i-1];
      end
    end
  end

  // Gated by reset so nothing leaks out while reset is being held.
  assign resp_valid  = (tag_vld[LATENCY] && reset) ? (NREQ'(1) << tag_idx[LATENCY]) : '0;
  assign resp_result = unit_result;

`ifdef BF16_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREQ; i++) begin
        stat_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && stat_cnt[i] != 16'hFFFF) begin
          stat_cnt[i] <= stat_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stat_count = '0;
    for (int i = 0; i < NREQ; i++) begin
      stat_count[i*16 +: 16] = stat_cnt[i];
    end
  end
`else
  assign stat_count = '0;
`endif

endmodule

// File: tb/tb_bf16_unit_arbiter.sv
module tb_bf16_unit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        arb_hold;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_in1, req_in2, req_in3;
  logic [9:0]  req_funct5;
  logic [15:0] unit_in1, unit_in2, unit_in3;
  logic [4:0]  unit_funct5;
  logic        unit_issue;
  logic [15:0] unit_result;
  logic [1:0]  resp_valid;
  logic [15:0] resp_result;
  logic [31:0] stat_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bf16_unit_arbiter #(.NREQ(2), .LATENCY(3), .IDXW(1)) dut (
    .clk(clk), .reset(reset), .arb_hold(arb_hold),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_in3(req_in3), .req_funct5(req_funct5),
    .unit_in1(unit_in1), .unit_in2(unit_in2), .unit_in3(unit_in3),
    .unit_funct5(unit_funct5), .unit_issue(unit_issue), .unit_result(unit_result),
    .resp_valid(resp_valid), .resp_result(resp_result), .stat_count(stat_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  e_rdy, e_rsp;
  logic        e_iss;
  logic [15:0] e_in1;
  logic [1:0]  hold_rdy [0:10];
  logic [1:0]  hold_rsp [0:10];
  logic [1:0]  rst_rdy  [0:9];
  logic [31:0] e_stat;

  initial begin
    reset = 1'b0; arb_hold = 1'b0; req_valid = '0;
    req_in1 = '0; req_in2 = '0; req_in3 = '0; req_funct5 = '0; unit_result = '0;

    // Reset held for two edges.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_issue", unit_issue, 0);
    chk("rst_resp", resp_valid, 0);
    chk("rst_in1", unit_in1, 0);
    chk("rst_stat", stat_count, 0);

    // Release with both requesters already valid: no grant on the first cycle.
    next_cycle();
    reset = 1'b1; req_valid = 2'b11;
    req_in1 = {16'h0B01, 16'h0A00}; req_in2 = {16'h0B02, 16'h0A02};
    req_in3 = {16'h0B03, 16'h0A03}; req_funct5 = {5'd3, 5'd1};
    @(negedge clk);
    chk("rel_ready", req_ready, 0);
    chk("rel_issue", unit_issue, 0);
    chk("rel_in1", unit_in1, 0);
    chk("rel_f5", unit_funct5, 0);
    chk("rel_resp", resp_valid, 0);

    // Both valid for 6 cycles: grants 0,1,0,1,0,1 and responses 4 cycles later.
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      req_valid   = (k < 6) ? 2'b11 : 2'b00;
      unit_result = 16'hC000 | 16'(k);
      e_rdy = (k < 6) ? ((k % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_rsp = (k >= 4 && k < 10) ? (((k - 4) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_iss = (k >= 1 && k <= 6);
      e_in1 = (k == 0) ? 16'h0000 : (k > 6) ? 16'h0B01 :
              (((k - 1) % 2 == 1) ? 16'h0B01 : 16'h0A00);
      @(negedge clk);
      chk($sformatf("rr_ready_%0d", k), req_ready, e_rdy);
      chk($sformatf("rr_resp_%0d", k), resp_valid, e_rsp);
      chk($sformatf("rr_issue_%0d", k), unit_issue, e_iss);
      chk($sformatf("rr_in1_%0d", k), unit_in1, e_in1);
      if (k == 4) chk("rr_result_4", resp_result, 16'hC004);
    end

    // Single request from requester 0.
    for (int k = 0; k <= 5; k++) begin
      next_cycle();
      if (k == 0) begin
        req_valid = 2'b01;
        req_in1 = {16'hFFFF, 16'h3F80}; req_in2 = {16'hFFFF, 16'h4000};
        req_in3 = {16'hFFFF, 16'h3F80}; req_funct5 = {5'd31, 5'd0};
      end else begin
        req_valid = 2'b00;
      end
      unit_result = (k == 4) ? 16'h4040 : 16'h1234;
      @(negedge clk);
      chk($sformatf("one_ready_%0d", k), req_ready, (k == 0) ? 2'b01 : 2'b00);
      chk($sformatf("one_issue_%0d", k), unit_issue, (k == 1) ? 1'b1 : 1'b0);
      chk($sformatf("one_resp_%0d", k), resp_valid, (k == 4) ? 2'b01 : 2'b00);
      if (k == 1) begin
        chk("one_in1", unit_in1, 16'h3F80);
        chk("one_in2", unit_in2, 16'h4000);
        chk("one_in3", unit_in3, 16'h3F80);
        chk("one_f5", unit_funct5, 5'd0);
      end
      if (k == 2) chk("one_in1_held", unit_in1, 16'h3F80);
      if (k == 4) chk("one_result", resp_result, 16'h4040);
    end

    // arb_hold over three cycles with both requesters valid.
    req_in1 = {16'h0B01, 16'h0A00}; req_funct5 = {5'd3, 5'd1};
    hold_rdy = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    hold_rsp = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
    for (int k = 0; k <= 10; k++) begin
      next_cycle();
      req_valid = (k < 6) ? 2'b11 : 2'b00;
      arb_hold  = (k >= 2 && k <= 4);
      @(negedge clk);
      chk($sformatf("hold_ready_%0d", k), req_ready, hold_rdy[k]);
      chk($sformatf("hold_resp_%0d", k), resp_valid, hold_rsp[k]);
      chk($sformatf("hold_issue_%0d", k), unit_issue, (k == 1 || k == 2 || k == 6) ? 1'b1 : 1'b0);
      if (k == 2) chk("hold_in1", unit_in1, 16'h0A00);
    end
    arb_hold = 1'b0;

    // Three in flight, then reset for one cycle: they never respond.
    rst_rdy = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    for (int k = 0; k <= 9; k++) begin
      next_cycle();
      req_valid = (k <= 5) ? 2'b11 : 2'b00;
      reset     = (k == 3) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("mid_ready_%0d", k), req_ready, rst_rdy[k]);
      chk($sformatf("mid_resp_%0d", k), resp_valid, (k == 9) ? 2'b01 : 2'b00);
      chk($sformatf("mid_issue_%0d", k), unit_issue, (k >= 1 && k <= 3) || k == 6);
      if (k == 4) chk("mid_in1_cleared", unit_in1, 16'h0000);
    end

    // Fresh reset, then five grants to requester 1.
    next_cycle();
    reset = 1'b0; req_valid = 2'b00;
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("stat_after_rst", stat_count, 0);
    for (int k = 0; k < 5; k++) begin
      next_cycle();
      req_valid = 2'b10;
      @(negedge clk);
      chk($sformatf("stat_ready_%0d", k), req_ready, 2'b10);
    end
    next_cycle();
    req_valid = 2'b00;
`ifdef BF16_ARB_STATS_EN
    e_stat = 32'h0005_0000;
`else
    e_stat = 32'h0000_0000;
`endif
    @(negedge clk);
    chk("stat_count", stat_count, e_stat);

    repeat (2) next_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bf16_unit_arbiter.md
Name: bf16_unit_arbiter

Overview:
- Shares one pipelined bf16 arithmetic datapath (fmadd/fmsub family, fixed pipeline latency) between NREQ independent requesters.
- Each requester presents operands and funct5 over a valid/ready handshake. The arbiter picks one per cycle round-robin and registers the operands into the datapath.
- A tag shift register tracks which requester owns each in-flight operation, so the arbiter can route the result back with a one-cycle resp_valid pulse.
- Sits between the issue logic and the bf16 unit instance.

Parameters:
- NREQ, 2: number of requesters (2..8).
- LATENCY, 3: cycles from unit_* inputs changing to the matching unit_result being valid.
- IDXW, 1: width of the requester index; must equal max(1, clog2(NREQ)).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- arb_hold  input  1  when 1, no new grants are issued; in-flight operations still complete.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant; handshake when valid & ready.
- req_in1  input  16*NREQ  operand 1; slice i belongs to requester i.
- req_in2  input  16*NREQ  operand 2, sliced per requester.
- req_in3  input  16*NREQ  operand 3, sliced per requester.
- req_funct5  input  5*NREQ  operation select, sliced per requester.
- unit_in1, unit_in2, unit_in3  output  16 each  registered operands to the datapath.
- unit_funct5  output  5  registered funct5 to the datapath.
- unit_issue  output  1  registered; 1 when unit_* carry a real operation.
- unit_result  input  16  datapath result.
- resp_valid  output  NREQ  one-hot pulse marking the result owner.
- resp_result  output  16  equals unit_result (combinational pass-through).
- stat_count  output  16*NREQ  per-requester issue counters (see Optional Feature).

Behaviour:
- Reset (reset==0 at a clock edge):
  - unit_in1/2/3, unit_funct5 and unit_issue go to 0.
  - Round-robin pointer goes to NREQ-1, so requester 0 has first priority.
  - Tag pipeline is cleared: all stages invalid.
  - Result: resp_valid=0 and req_ready=0 while reset is low, and on the first cycle after release.
- Reset mid-operation: in-flight operations are discarded and never produce resp_valid. Their unit_result values are ignored.
- Arbitration (combinational):
  - Search req_valid starting at pointer+1, wrapping modulo NREQ. The first set bit gets req_ready=1; all other bits are 0.
  - At most one req_ready bit is set per cycle.
  - req_ready is 0 for all requesters when arb_hold=1 or no request is valid.
  - req_ready may depend on req_valid. A requester must not drop req_valid until its handshake.
- On a handshake from requester g at a clock edge:
  - unit_in1/2/3 and unit_funct5 load slice g; unit_issue<=1; pointer<=g.
  - Tag stage 0 <= {valid=1, idx=g}.
- With no handshake: unit_issue<=0; unit_* operands hold their previous values; pointer is unchanged; tag stage 0 <= invalid.
- Tag pipeline: LATENCY+1 stages, shifting every cycle, with no stall.
  - When the last stage is valid with idx=k: resp_valid[k]=1 and resp_result=unit_result.
  - End to end, a handshake in cycle t gives resp_valid in cycle t+LATENCY+1.
- Throughput: one issue per cycle, back-to-back, with no bubbles. There is no response backpressure; requesters must always accept responses.
- Simultaneous events:
  - A new grant and a response in the same cycle are independent.
  - The same requester may be granted again in the cycle its earlier response returns.
- Fairness: with all NREQ requests held continuously valid, grant order is 0,1,…,NREQ-1,0,…

Optional Feature:
- Macro BF16_ARB_STATS_EN.
- Defined:
  - Slice i of stat_count counts handshakes of requester i and saturates at 0xFFFF.
  - Counters clear on reset.
- Undefined: no counter registers exist and stat_count is tied to 0. The port list is unchanged.

Test Plan:
- NREQ=2, LATENCY=3; reset low 2 cycles, then released with no requests → req_ready=0, unit_issue=0, resp_valid=0, unit_* = 0.
- Requester 0 only, handshake in cycle 10 with in1=0x3F80, in2=0x4000, in3=0x3F80, funct5=0 → unit_in1=0x3F80 and unit_issue=1 in cycle 11; resp_valid=2'b01 in cycle 14; resp_result equals the unit_result driven that cycle.
- Both requesters continuously valid for 6 cycles → grants alternate 0,1,0,1,0,1; resp_valid alternates 01,10,… starting 4 cycles after the first grant; no gaps.
- arb_hold=1 in cycles 20–22 with both requests valid → req_ready=0 for those cycles; operations issued before cycle 20 still return resp_valid on schedule.
- Three operations in flight, then reset low for 1 cycle → no resp_valid for any of them; the first grant after release goes to requester 0.
- With BF16_ARB_STATS_EN: 5 grants to requester 1 → stat_count[31:16]=5, stat_count[15:0]=0. Without the macro → stat_count=0.
